// File: rtl/enemy_spawner.sv
// Beat-driven enemy spawn scheduler: rolls the LFSR word against a spawn threshold and
// offers {lane, kind} over valid/ready, with post-spawn cooldown and an alive-enemy cap.
module enemy_spawner #(
    parameter int unsigned LANES          = 4,
    parameter int unsigned COOLDOWN_BEATS = 2,
    parameter int unsigned MAX_ACTIVE     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat,
    input  logic        enable,
    input  logic [15:0] rand_in,
    input  logic [7:0]  spawn_thresh,
    input  logic        kill,
    output logic        spawn_valid,
    input  logic        spawn_ready,
    output logic [3:0]  spawn_lane,
    output logic [1:0]  spawn_kind,
    output logic [7:0]  active_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OFFER = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    localparam logic [3:0]  COOL_INIT = 4'(COOLDOWN_BEATS);
    localparam logic [7:0]  CAP       = 8'(MAX_ACTIVE);
    localparam logic [11:0] LANES_W   = 12'(LANES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cool_q, cool_d;
    logic [3:0]  lane_q, lane_d;
    logic [1:0]  kind_q, kind_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    logic        roll_en;
    logic        roll_hit;
    logic        handshake;
    logic [11:0] lane_prod;
    logic [3:0]  lane_calc;

    assign roll_en   = (state_q == IDLE) & beat & enable & (cnt_q < CAP);
    assign roll_hit  = roll_en & (rand_in[15:8] < spawn_thresh);
    assign handshake = valid_q & spawn_ready;

    // Scale the low byte into [0, LANES) without a divider.
    assign lane_prod = {4'd0, rand_in[7:0]} * LANES_W;
    assign lane_calc = 4'(lane_prod >> 8);

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        lane_d  = lane_q;
        kind_d  = kind_q;
        unique case (state_q)
            IDLE: begin
                if (roll_hit) begin
                    state_d = OFFER;
                    lane_d  = lane_calc;
                    kind_d  = {rand_in[1] ^ rand_in[9], rand_in[0] ^ rand_in[8]};
                end
            end
            OFFER: begin
                if (spawn_ready) begin
                    cool_d  = COOL_INIT;
                    state_d = (COOL_INIT == 4'd0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (cool_q == 4'd0) begin
                    state_d = IDLE;
                end else if (beat) begin
                    // The beat that empties the cooldown only re-arms; it never rolls.
                    cool_d = cool_q - 4'd1;
                    if (cool_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = (state_d == OFFER);
        cnt_d   = cnt_q;
        if (handshake && !kill) begin
            cnt_d = cnt_q + 8'd1;
        end else if (kill && !handshake && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cool_q  <= 4'd0;
            lane_q  <= 4'd0;
            kind_q  <= 2'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            lane_q  <= lane_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign spawn_kind  = kind_q;
    assign active_cnt  = cnt_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Scoreboard bench for enemy_spawner: a default instance (4 lanes, cooldown 2, cap 8) and a
// narrow instance (3 lanes, no cooldown, cap 2) share rand/threshold/enable stimulus.
module tb_enemy_spawner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] rand_in;
    logic [7:0]  spawn_thresh;

    logic        beat_a, kill_a, ready_a, spawn_valid_a;
    logic [3:0]  spawn_lane_a;
    logic [1:0]  spawn_kind_a;
    logic [7:0]  active_cnt_a;

    logic        beat_b, kill_b, ready_b, spawn_valid_b;
    logic [3:0]  spawn_lane_b;
    logic [1:0]  spawn_kind_b;
    logic [7:0]  active_cnt_b;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] sb_a[$];
    logic [5:0] sb_b[$];
    logic [5:0] exp_a, exp_b;
    logic       prev_a = 1'b0;
    logic       prev_b = 1'b0;

    enemy_spawner #(
        .LANES(4),
        .COOLDOWN_BEATS(2),
        .MAX_ACTIVE(8)
    ) u_dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .beat(beat_a),
        .enable(enable),
        .rand_in(rand_in),
        .spawn_thresh(spawn_thresh),
        .kill(kill_a),
        .spawn_valid(spawn_valid_a),
        .spawn_ready(ready_a),
        .spawn_lane(spawn_lane_a),
        .spawn_kind(spawn_kind_a),
        .active_cnt(active_cnt_a)
    );

    enemy_spawner #(
        .LANES(3),
        .COOLDOWN_BEATS(0),
        .MAX_ACTIVE(2)
    ) u_dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .beat(beat_b),
        .enable(enable),
        .rand_in(rand_in),
        .spawn_thresh(spawn_thresh),
        .kill(kill_b),
        .spawn_valid(spawn_valid_b),
        .spawn_ready(ready_b),
        .spawn_lane(spawn_lane_b),
        .spawn_kind(spawn_kind_b),
        .active_cnt(active_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference spawn result {lane[3:0], kind[1:0]} for a hitting roll.
    function automatic logic [5:0] model(input logic [15:0] r, input int unsigned lanes);
        int unsigned l;
        l = (32'(r[7:0]) * lanes) / 256;
        return {4'(l), r[1] ^ r[9], r[0] ^ r[8]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        beat_a  = 1'b0;
        beat_b  = 1'b0;
        kill_a  = 1'b0;
        kill_b  = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    // Each new offer must match the oldest expected spawn.
    always @(negedge clk) begin
        if (spawn_valid_a && !prev_a) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_spawn", 32'(spawn_valid_a), 0);
            end else begin
                exp_a = sb_a.pop_front();
                check("a_lane", 32'(spawn_lane_a), 32'(exp_a[5:2]));
                check("a_kind", 32'(spawn_kind_a), 32'(exp_a[1:0]));
            end
        end
        if (spawn_valid_b && !prev_b) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_spawn", 32'(spawn_valid_b), 0);
            end else begin
                exp_b = sb_b.pop_front();
                check("b_lane", 32'(spawn_lane_b), 32'(exp_b[5:2]));
                check("b_kind", 32'(spawn_kind_b), 32'(exp_b[1:0]));
            end
        end
        prev_a <= spawn_valid_a;
        prev_b <= spawn_valid_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; rand_in = '0; spawn_thresh = '0;
        beat_a = 1'b0; kill_a = 1'b0; ready_a = 1'b0;
        beat_b = 1'b0; kill_b = 1'b0; ready_b = 1'b0;
        #12;
        check("rst_valid_a", 32'(spawn_valid_a), 0);
        check("rst_cnt_a", 32'(active_cnt_a), 0);
        check("rst_lane_a", 32'(spawn_lane_a), 0);
        check("rst_kind_a", 32'(spawn_kind_a), 0);
        check("rst_valid_b", 32'(spawn_valid_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Instance A: roll math, lane 3 kind 3
        enable = 1'b1; spawn_thresh = 8'h80; rand_in = 16'h40C3; beat_a = 1'b1;
        sb_a.push_back(model(16'h40C3, 4));
        tick();
        check("a_roll_valid", 32'(spawn_valid_a), 1);

        // Backpressure: beats and enable toggling must not disturb the offer
        for (int i = 0; i < 10; i++) begin
            beat_a  = (i % 3 == 1);
            enable  = i[0];
            rand_in = 16'($urandom);
            tick();
            check("bp_valid", 32'(spawn_valid_a), 1);
            check("bp_lane", 32'(spawn_lane_a), 3);
            check("bp_kind", 32'(spawn_kind_a), 3);
        end
        enable = 1'b1;
        ready_a = 1'b1;
        tick();
        check("bp_hs_valid", 32'(spawn_valid_a), 0);
        check("bp_hs_cnt", 32'(active_cnt_a), 1);

        // Cooldown of 2: beats 1 and 2 never roll, beat 3 does; enable low does not pause it
        spawn_thresh = 8'hFF; rand_in = 16'h0000;
        enable = 1'b0; beat_a = 1'b1; tick();
        check("cool_beat1", 32'(spawn_valid_a), 0);
        enable = 1'b1;
        tick();
        beat_a = 1'b1; tick();
        check("cool_beat2", 32'(spawn_valid_a), 0);
        tick();
        check("cool_gap", 32'(spawn_valid_a), 0);
        beat_a = 1'b1; sb_a.push_back(model(16'h0000, 4)); tick();
        check("cool_beat3", 32'(spawn_valid_a), 1);
        ready_a = 1'b1; tick();
        check("a_cnt2", 32'(active_cnt_a), 2);

        // Failed roll: 0x90 >= 0x80
        beat_a = 1'b1; tick();
        beat_a = 1'b1; tick();
        spawn_thresh = 8'h80; rand_in = 16'h90C3; beat_a = 1'b1; tick();
        check("a_miss_valid", 32'(spawn_valid_a), 0);
        tick();
        check("a_miss_hold", 32'(spawn_valid_a), 0);

        kill_a = 1'b1; tick();
        check("a_kill_cnt", 32'(active_cnt_a), 1);

        // Handshake and kill together leave the count alone
        spawn_thresh = 8'hFF; rand_in = 16'h0000; beat_a = 1'b1;
        sb_a.push_back(model(16'h0000, 4));
        tick();
        check("a_sim_valid", 32'(spawn_valid_a), 1);
        ready_a = 1'b1; kill_a = 1'b1; tick();
        check("a_sim_cnt", 32'(active_cnt_a), 1);
        check("a_sim_drop", 32'(spawn_valid_a), 0);

        // ---- Instance B: 3 lanes, no cooldown, cap 2
        spawn_thresh = 8'hFF; rand_in = 16'h00FF; beat_b = 1'b1;
        sb_b.push_back(model(16'h00FF, 3));
        tick();
        check("b_roll1", 32'(spawn_valid_b), 1);
        check("b_lane_ff", 32'(spawn_lane_b), 2);
        // A beat in the handshake cycle is ignored even with no cooldown
        ready_b = 1'b1; beat_b = 1'b1; tick();
        check("b_hs_beat", 32'(spawn_valid_b), 0);
        check("b_cnt1", 32'(active_cnt_b), 1);

        rand_in = 16'h0055; beat_b = 1'b1;
        sb_b.push_back(model(16'h0055, 3));
        tick();
        check("b_roll2", 32'(spawn_valid_b), 1);
        check("b_lane_55", 32'(spawn_lane_b), 0);
        ready_b = 1'b1; tick();
        check("b_cnt2", 32'(active_cnt_b), 2);

        rand_in = 16'h0056;
        for (int i = 0; i < 4; i++) begin
            beat_b = 1'b1; tick();
            check("b_cap", 32'(spawn_valid_b), 0);
        end
        kill_b = 1'b1; tick();
        check("b_kill1", 32'(active_cnt_b), 1);
        beat_b = 1'b1; sb_b.push_back(model(16'h0056, 3)); tick();
        check("b_roll3", 32'(spawn_valid_b), 1);
        check("b_lane_56", 32'(spawn_lane_b), 1);
        ready_b = 1'b1; kill_b = 1'b1; tick();
        check("b_sim_cnt", 32'(active_cnt_b), 1);
        kill_b = 1'b1; tick();
        check("b_kill2", 32'(active_cnt_b), 0);
        kill_b = 1'b1; tick();
        check("b_kill_at0", 32'(active_cnt_b), 0);

        // Roll of 0xFF never beats thresh 0xFF
        rand_in = 16'hFF00; spawn_thresh = 8'hFF; beat_b = 1'b1; tick();
        check("b_roll_ff", 32'(spawn_valid_b), 0);

        spawn_thresh = 8'h00;
        for (int i = 0; i < 100; i++) begin
            rand_in = 16'($urandom); beat_b = 1'b1; tick();
            check("b_thresh0", 32'(spawn_valid_b), 0);
        end

        // ---- Async reset mid-offer on A
        beat_a = 1'b1; tick();
        beat_a = 1'b1; tick();
        spawn_thresh = 8'h80; rand_in = 16'h40C3; beat_a = 1'b1;
        sb_a.push_back(model(16'h40C3, 4));
        tick();
        check("a_pre_rst_valid", 32'(spawn_valid_a), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(spawn_valid_a), 0);
        check("mid_rst_cnt", 32'(active_cnt_a), 0);
        check("mid_rst_lane", 32'(spawn_lane_a), 0);
        check("mid_rst_kind", 32'(spawn_kind_a), 0);
        #10;
        rst_n = 1'b1;
        tick();

        check("a_sb_empty", 32'(sb_a.size()), 0);
        check("b_sb_empty", 32'(sb_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Random-driven enemy spawn scheduler; consumes the 16-bit pseudo-random word from the free-running LFSR and turns it into at most one spawn request per beat. Each accepted beat rolls against a programmable spawn probability, maps random bits to a lane and enemy kind, and offers the result to the enemy table over a valid/ready handshake. Enforces a post-spawn cooldown and a cap on simultaneously alive enemies.

## Interface
- LANES, 4, number of spawn lanes (1..16, not required to be a power of two)
- COOLDOWN_BEATS, 2, beats skipped after an accepted spawn (0..15)
- MAX_ACTIVE, 8, maximum alive enemies tracked (1..255)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- beat  input  1  one-cycle rhythm pulse, synchronous to clk
- enable  input  1  gameplay running; low suppresses new rolls
- rand_in  input  16  current LFSR output word, sampled only on roll cycles
- spawn_thresh  input  8  spawn probability numerator out of 256
- kill  input  1  one-cycle pulse: one alive enemy destroyed
- spawn_valid  output  1  spawn request pending
- spawn_ready  input  1  enemy table accepts request
- spawn_lane  output  4  lane index, 0..LANES-1
- spawn_kind  output  2  enemy kind
- active_cnt  output  8  current alive-enemy count

## Operation
- States: IDLE, OFFER, COOL.
- Roll condition (IDLE only): beat & enable & (active_cnt < MAX_ACTIVE).
- On roll: roll = rand_in[15:8]; spawn iff roll < spawn_thresh (unsigned). thresh=0 never spawns; thresh=255 spawns unless roll=255.
- On successful roll latch: spawn_lane = (rand_in[7:0] * LANES) >> 8 (16-bit product, keep bits [11:8]); spawn_kind = {rand_in[1]^rand_in[9], rand_in[0]^rand_in[8]}; go OFFER.
- Failed roll: stay IDLE, outputs unchanged.
- OFFER: spawn_valid=1; spawn_lane/spawn_kind held stable until handshake; valid never withdrawn (enable low or beats do not cancel). Beats in OFFER are ignored, not queued.
- Handshake (spawn_valid & spawn_ready): active_cnt +1; load cooldown = COOLDOWN_BEATS; go COOL, or IDLE directly when COOLDOWN_BEATS=0.
- COOL: each beat decrements cooldown; the beat that reaches 0 moves to IDLE and does not roll. enable does not pause cooldown.
- kill: active_cnt -1, saturating at 0 (kill at 0 ignored).
- Simultaneous handshake and kill: active_cnt unchanged.
- active_cnt never exceeds MAX_ACTIVE (roll is blocked at the cap, so increment cannot overflow).
- rand_in is not sampled outside roll cycles; no other internal randomness.

## Timing
- Reset (rst_n low, async): state IDLE, spawn_valid=0, spawn_lane=0, spawn_kind=0, active_cnt=0, cooldown=0. Reset mid-OFFER drops the pending request immediately.
- Roll on beat at cycle N -> spawn_valid=1 at cycle N+1 (registered, one cycle latency).
- Handshake at cycle M -> spawn_valid=0 and active_cnt updated at M+1.
- Kill at cycle K -> active_cnt updated at K+1.
- Earliest next roll after handshake: the (COOLDOWN_BEATS+1)-th beat after the handshake cycle; with COOLDOWN_BEATS=0, the first beat after handshake (a beat in the handshake cycle itself is ignored).
- All outputs registered; no combinational path from spawn_ready to spawn_valid.

## Test plan
- Reset/default: rst_n low mid-OFFER -> spawn_valid=0, active_cnt=0, lane=0, kind=0 immediately, no clock edge required.
- Roll math, LANES=4: thresh=0x80, rand_in=0x40C3 on beat -> next cycle valid=1, lane=3, kind=2'b{1^0,1^0}=2'b11; rand_in=0x90C3 -> no spawn.
- Lane mapping, LANES=3: rand_in[7:0]=0xFF -> lane=2; 0x55 -> lane=0; 0x56 -> lane=1; thresh=0 for 100 beats -> no valid ever.
- Backpressure: hold spawn_ready=0 for 10 cycles with 3 beats and enable toggling -> valid stays 1, lane/kind constant; ready=1 -> one handshake, active_cnt=1.
- Cooldown, COOLDOWN_BEATS=2, thresh=255, rand_in[15:8]=0: handshake then beats -> beats 1,2 no roll, beat 3 rolls, valid next cycle.
- Cap and kill: MAX_ACTIVE=2, accept 2 spawns -> further beats never raise valid; kill same cycle as a handshake -> count unchanged; kill at count 0 -> stays 0.
